// File: rtl/hex_segment_encoder_if.sv
// Handshake bundle for the segment-pattern encoder: pattern in, buffered digit out.
// The encoder takes the slave modport; the producer/consumer side takes master.
interface hex_segment_encoder_if #(
  parameter int AW = 3
);
  logic [6:0]  seg_in;
  logic        seg_valid;
  logic        seg_ready;
  logic [3:0]  out_digit;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [AW:0] level;
  logic [7:0]  err_count;

  modport slave (
    input  seg_in, seg_valid, out_ready,
    output seg_ready, out_digit, out_err, out_valid, level, err_count
  );

  modport master (
    output seg_in, seg_valid, out_ready,
    input  seg_ready, out_digit, out_err, out_valid, level, err_count
  );
endinterface

// File: rtl/hex_segment_encoder.sv
// Encodes active-low 7-seg patterns to hex digits into a DEPTH-entry FIFO; stored at the accept edge,
// visible after it. seg_ready = ~full (no pass-through when full); head holds while out_ready is low.
module hex_segment_encoder #(
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter bit DROP_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 resetn,
  hex_segment_encoder_if.slave bus
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  if (DEPTH != (1 << AW) || DEPTH < 2 || DEPTH > 16) begin : g_bad_param
    $error("hex_segment_encoder: DEPTH must be a power of two in 2..16 and equal 2**AW");
  end

  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    err_q, err_d;

  logic [3:0] enc_digit;
  logic       enc_err;
  logic       push_ok, push_wr, pop;

  always_comb begin
    enc_digit = 4'h0;
    enc_err   = 1'b0;
    unique case (bus.seg_in)
      7'h40: enc_digit = 4'h0;
      7'h79: enc_digit = 4'h1;
      7'h24: enc_digit = 4'h2;
      7'h30: enc_digit = 4'h3;
      7'h19: enc_digit = 4'h4;
      7'h12: enc_digit = 4'h5;
      7'h02: enc_digit = 4'h6;
      7'h78: enc_digit = 4'h7;
      7'h00: enc_digit = 4'h8;
      7'h10: enc_digit = 4'h9;
      7'h08: enc_digit = 4'hA;
      7'h03: enc_digit = 4'hB;
      7'h46: enc_digit = 4'hC;
      7'h21: enc_digit = 4'hD;
      7'h06: enc_digit = 4'hE;
      7'h0E: enc_digit = 4'hF;
      default: enc_err = 1'b1;
    endcase
  end

  assign bus.seg_ready = (level_q != FULL_LVL);
  assign bus.out_valid = (level_q != '0);

  assign push_ok = bus.seg_valid & bus.seg_ready;
  // A dropped invalid pattern still counts as accepted for err_count.
  assign push_wr = push_ok & (~enc_err | ~DROP_ERR);
  assign pop     = bus.out_valid & bus.out_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    err_d   = err_q;
    if (push_wr) wptr_d = wptr_q + AW'(1);
    if (pop)     rptr_d = rptr_q + AW'(1);
    if (push_wr && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push_wr && pop) level_d = level_q - (AW+1)'(1);
    if (push_ok && enc_err && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      err_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_wr) mem_q[wptr_q] <= {enc_err, enc_digit};
  end

  // Storage is not reset, so the head is masked to zero whenever the FIFO is empty.
  assign bus.out_digit = bus.out_valid ? mem_q[rptr_q][3:0] : 4'h0;
  assign bus.out_err   = bus.out_valid & mem_q[rptr_q][4];
  assign bus.level     = level_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_hex_segment_encoder.sv
// Scoreboard bench: u_dut (DROP_ERR=0) is fully checked, u_drop (DROP_ERR=1) checks level/err_count.
module tb_hex_segment_encoder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hex_segment_encoder_if #(.AW(3)) bus_a ();
  hex_segment_encoder_if #(.AW(3)) bus_b ();

  hex_segment_encoder #(.DEPTH(8), .AW(3), .DROP_ERR(1'b0)) u_dut (
    .clk(clk), .resetn(resetn), .bus(bus_a)
  );
  hex_segment_encoder #(.DEPTH(8), .AW(3), .DROP_ERR(1'b1)) u_drop (
    .clk(clk), .resetn(resetn), .bus(bus_b)
  );

  logic [6:0] pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int errs = 0;
  int checks = 0;
  logic [4:0] sb [$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {err, digit}; unknown patterns give err=1, digit=0
  function automatic logic [4:0] model(input logic [6:0] p);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++)
      if (pats[i] == p) r = 5'(i);
    return r;
  endfunction

  always @(negedge clk) begin
    logic [4:0] e;
    if (resetn) begin
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", bus_a.out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("out_digit", bus_a.out_digit, e[3:0]);
          chk("out_err", bus_a.out_err, e[4]);
        end
      end
      if (bus_a.seg_valid && bus_a.seg_ready) sb.push_back(model(bus_a.seg_in));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.seg_in = 7'h7F; bus_a.seg_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.seg_in = 7'h7F; bus_b.seg_valid = 1'b0; bus_b.out_ready = 1'b1;

    #12;
    chk("rst_level", bus_a.level, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_seg_ready", bus_a.seg_ready, 1);
    chk("rst_err_count", bus_a.err_count, 0);
    chk("rst_out_digit", bus_a.out_digit, 0);
    chk("rst_out_err", bus_a.out_err, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    cyc(1);

    // All 16 glyphs, one at a time: visible one edge after acceptance
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_a.seg_in = pats[i];
      bus_a.seg_valid = 1'b1;
      cyc(1);
      bus_a.seg_valid = 1'b0;
      chk("lat_valid", bus_a.out_valid, 1);
      chk("lat_level", bus_a.level, 1);
      cyc(1);
    end
    chk("glyph_drained", bus_a.out_valid, 0);

    // Fill to full and attempt one more
    bus_a.out_ready = 1'b0;
    bus_a.seg_in = 7'h24;
    bus_a.seg_valid = 1'b1;
    cyc(8);
    chk("full_seg_ready", bus_a.seg_ready, 0);
    chk("full_level", bus_a.level, 8);
    cyc(1);
    chk("full_ninth_level", bus_a.level, 8);
    bus_a.seg_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    cyc(8);
    chk("full_drain_valid", bus_a.out_valid, 0);
    chk("full_drain_level", bus_a.level, 0);
    chk("full_sb_left", sb.size(), 0);

    // Invalid patterns: stored with err (DROP_ERR=0) vs dropped (DROP_ERR=1)
    bus_a.out_ready = 1'b0;
    bus_a.seg_in = 7'h7F; bus_a.seg_valid = 1'b1;
    bus_b.seg_in = 7'h7F; bus_b.seg_valid = 1'b1;
    cyc(1);
    bus_a.seg_in = 7'h55;
    bus_b.seg_in = 7'h55;
    cyc(1);
    bus_a.seg_valid = 1'b0;
    bus_b.seg_valid = 1'b0;
    chk("err_keep_level", bus_a.level, 2);
    chk("err_keep_count", bus_a.err_count, 2);
    chk("err_drop_level", bus_b.level, 0);
    chk("err_drop_count", bus_b.err_count, 2);
    chk("err_drop_valid", bus_b.out_valid, 0);
    bus_a.out_ready = 1'b1;
    cyc(2);
    chk("err_drained", bus_a.out_valid, 0);

    // Steady push+pop at level 4 with pointer wrap
    bus_a.out_ready = 1'b0;
    bus_a.seg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_a.seg_in = pats[i+1];
      cyc(1);
    end
    chk("stream_fill_level", bus_a.level, 4);
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus_a.seg_in = pats[(i+5) % 16];
      cyc(1);
      chk("stream_level", bus_a.level, 4);
    end
    bus_a.seg_valid = 1'b0;
    cyc(4);
    chk("stream_drained", bus_a.out_valid, 0);
    chk("stream_sb_left", sb.size(), 0);

    // err_count saturation
    bus_a.seg_in = 7'h7F;
    bus_a.seg_valid = 1'b1;
    cyc(300);
    bus_a.seg_valid = 1'b0;
    cyc(2);
    chk("sat_err_count", bus_a.err_count, 255);
    chk("sat_drained", bus_a.out_valid, 0);

    // Asynchronous reset with three entries held
    bus_a.out_ready = 1'b0;
    bus_a.seg_valid = 1'b1;
    bus_a.seg_in = 7'h30; cyc(1);
    bus_a.seg_in = 7'h12; cyc(1);
    bus_a.seg_in = 7'h02; cyc(1);
    bus_a.seg_valid = 1'b0;
    chk("mid_level", bus_a.level, 3);
    chk("mid_head", bus_a.out_digit, 3);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", bus_a.out_valid, 0);
    chk("arst_level", bus_a.level, 0);
    chk("arst_out_digit", bus_a.out_digit, 0);
    chk("arst_err_count", bus_a.err_count, 0);
    chk("arst_seg_ready", bus_a.seg_ready, 1);
    sb.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    bus_a.seg_in = 7'h0E;
    bus_a.seg_valid = 1'b1;
    cyc(1);
    bus_a.seg_valid = 1'b0;
    chk("post_rst_level", bus_a.level, 1);
    bus_a.out_ready = 1'b1;
    cyc(2);
    chk("post_rst_drained", bus_a.out_valid, 0);
    chk("post_rst_sb_left", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
